// File: rtl/rv32_trap_ctrl_if.sv
// Core-side bundle for the machine-mode trap controller: interrupt lines,
// commit/exception information, CSR access port and redirect outputs.
interface rv32_trap_ctrl_if #(
    parameter int N_EXT_IRQ = 8
);
    logic                 irq_software;
    logic                 irq_timer;
    logic [N_EXT_IRQ-1:0] irq_external;
    logic                 instr_commit;
    logic [31:0]          actual_pc;
    logic                 exc_valid;
    logic [3:0]           exc_cause;
    logic [31:0]          exc_tval;
    logic                 mret_commit;
    logic [1:0]           csr_op;
    logic [11:0]          csr_addr;
    logic [31:0]          csr_wdata;
    logic [31:0]          csr_rdata;
    logic                 take_trap;
    logic [31:0]          trap_pc;
    logic                 take_return;
    logic [31:0]          return_pc;

    modport master (
        output irq_software, irq_timer, irq_external,
        output instr_commit, actual_pc, exc_valid, exc_cause, exc_tval, mret_commit,
        output csr_op, csr_addr, csr_wdata,
        input  csr_rdata, take_trap, trap_pc, take_return, return_pc
    );

    modport slave (
        input  irq_software, irq_timer, irq_external,
        input  instr_commit, actual_pc, exc_valid, exc_cause, exc_tval, mret_commit,
        input  csr_op, csr_addr, csr_wdata,
        output csr_rdata, take_trap, trap_pc, take_return, return_pc
    );
endinterface

// File: rtl/rv32_trap_ctrl.sv
// RV32 machine-mode trap controller: M-mode CSRs, interrupt arbitration,
// trap/return redirect and a small external-interrupt aggregator.
module rv32_trap_ctrl #(
    parameter int                   N_EXT_IRQ   = 8,
    parameter logic [31:0]          RESET_MTVEC = 32'h0000_1000,
    parameter logic [N_EXT_IRQ-1:0] EXT_EDGE    = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    rv32_trap_ctrl_if.slave bus
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MEXTIE   = 12'hBC0;
    localparam logic [11:0] A_MEXTCLR  = 12'h BC1;
    localparam logic [11:0] A_MEXTIP   = 12'h FC0;
    localparam logic [11:0] A_MEXTID   = 12'h FC1;

    localparam logic [31:0] MIE_MASK   = 32'h0000_0888;
    localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFD;

    localparam logic [3:0] CODE_SW  = 4'd3;
    localparam logic [3:0] CODE_TM  = 4'd7;
    localparam logic [3:0] CODE_EXT = 4'd11;

    // Read-modify-write operand for the CSR port.
    function automatic logic [31:0] csr_alu(input logic [1:0]  op,
                                            input logic [31:0] old,
                                            input logic [31:0] operand);
        logic [31:0] res;
        unique case (op)
            2'b01:   res = operand;
            2'b10:   res = old | operand;
            2'b11:   res = old & ~operand;
            default: res = old;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] zext(input logic [N_EXT_IRQ-1:0] v);
        return {{(32 - N_EXT_IRQ){1'b0}}, v};
    endfunction

    logic                 st_mie;
    logic                 st_mpie;
    logic [31:0]          mie_q;
    logic [31:0]          mtvec_q;
    logic [31:0]          mscratch_q;
    logic [31:0]          mepc_q;
    logic [31:0]          mcause_q;
    logic [31:0]          mtval_q;
    logic [N_EXT_IRQ-1:0] mextie_q;
    logic [N_EXT_IRQ-1:0] ext_prev_q;
    logic [N_EXT_IRQ-1:0] ext_latch_q;

    logic [N_EXT_IRQ-1:0] ext_pend;
    logic [N_EXT_IRQ-1:0] ext_act;
    logic [N_EXT_IRQ-1:0] ext_rise;
    logic [N_EXT_IRQ-1:0] ext_clr;
    logic                 ext_any;
    logic [31:0]          mextid;
    logic [31:0]          mstatus_val;
    logic [31:0]          mip_val;
    logic                 sw_elig;
    logic                 tm_elig;
    logic                 ext_elig;
    logic                 irq_any;
    logic [3:0]           irq_code;
    logic [31:0]          tvec_base;
    logic                 trap;
    logic                 ret;
    logic                 csr_we;
    logic [31:0]          csr_rd;
    logic [31:0]          csr_wval;

    // Level lines pass straight through; edge lines come from the latch.
    assign ext_pend = (EXT_EDGE & ext_latch_q) | (~EXT_EDGE & bus.irq_external);
    assign ext_act  = ext_pend & mextie_q;
    assign ext_any  = |ext_act;
    assign ext_rise = bus.irq_external & ~ext_prev_q;

    always_comb begin
        mextid = 32'd0;
        for (int i = N_EXT_IRQ - 1; i >= 0; i--) begin
            if (ext_act[i]) mextid = 32'(i + 1);
        end
    end

    assign mstatus_val = {24'b0, st_mpie, 3'b0, st_mie, 3'b0};
    assign mip_val     = {20'b0, ext_any, 3'b0, bus.irq_timer, 3'b0, bus.irq_software, 3'b0};

    assign sw_elig  = st_mie & mie_q[3]  & bus.irq_software;
    assign tm_elig  = st_mie & mie_q[7]  & bus.irq_timer;
    assign ext_elig = st_mie & mie_q[11] & ext_any;
    assign irq_any  = sw_elig | tm_elig | ext_elig;

    always_comb begin
        irq_code = CODE_SW;
        if (ext_elig)     irq_code = CODE_EXT;
        else if (tm_elig) irq_code = CODE_TM;
    end

    assign trap = bus.instr_commit & (bus.exc_valid | irq_any);
    assign ret  = bus.instr_commit & bus.mret_commit & ~trap;

    // Vectored mode only applies when an interrupt (not an exception) wins.
    assign tvec_base = {mtvec_q[31:2], 2'b00};
    always_comb begin
        bus.trap_pc = tvec_base;
        if (!bus.exc_valid && mtvec_q[0])
            bus.trap_pc = tvec_base + {26'b0, irq_code, 2'b00};
    end

    assign bus.take_trap   = trap;
    assign bus.take_return = ret;
    assign bus.return_pc   = mepc_q;

    always_comb begin
        csr_rd = 32'd0;
        unique case (bus.csr_addr)
            A_MSTATUS:  csr_rd = mstatus_val;
            A_MIE:      csr_rd = mie_q;
            A_MTVEC:    csr_rd = mtvec_q;
            A_MSCRATCH: csr_rd = mscratch_q;
            A_MEPC:     csr_rd = mepc_q;
            A_MCAUSE:   csr_rd = mcause_q;
            A_MTVAL:    csr_rd = mtval_q;
            A_MIP:      csr_rd = mip_val;
            A_MEXTIE:   csr_rd = zext(mextie_q);
            A_MEXTIP:   csr_rd = zext(ext_pend);
            A_MEXTID:   csr_rd = mextid;
            default:    csr_rd = 32'd0;
        endcase
    end
    assign bus.csr_rdata = csr_rd;

    assign csr_wval = csr_alu(bus.csr_op, csr_rd, bus.csr_wdata);
    assign csr_we   = (bus.csr_op != 2'b00) & ~trap & ~ret;
    assign ext_clr  = (csr_we && bus.csr_addr == A_MEXTCLR) ? csr_wval[N_EXT_IRQ-1:0] : '0;

    // A rising edge in the clear cycle is OR-ed in after the clear, so it wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_prev_q  <= '0;
            ext_latch_q <= '0;
        end else begin
            ext_prev_q  <= bus.irq_external;
            ext_latch_q <= EXT_EDGE & ((ext_latch_q & ~ext_clr) | ext_rise);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= RESET_MTVEC & MTVEC_MASK;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            mextie_q   <= '0;
        end else if (trap) begin
            mepc_q  <= {bus.actual_pc[31:1], 1'b0};
            st_mpie <= st_mie;
            st_mie  <= 1'b0;
            if (bus.exc_valid) begin
                mcause_q <= {28'b0, bus.exc_cause};
                mtval_q  <= bus.exc_tval;
            end else begin
                mcause_q <= {1'b1, 27'b0, irq_code};
                mtval_q  <= 32'd0;
            end
        end else if (ret) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
        end else if (csr_we) begin
            unique case (bus.csr_addr)
                A_MSTATUS: begin
                    st_mie  <= csr_wval[3];
                    st_mpie <= csr_wval[7];
                end
                A_MIE:      mie_q      <= csr_wval & MIE_MASK;
                A_MTVEC:    mtvec_q    <= csr_wval & MTVEC_MASK;
                A_MSCRATCH: mscratch_q <= csr_wval;
                A_MEPC:     mepc_q     <= {csr_wval[31:1], 1'b0};
                A_MCAUSE:   mcause_q   <= csr_wval;
                A_MTVAL:    mtval_q    <= csr_wval;
                A_MEXTIE:   mextie_q   <= csr_wval[N_EXT_IRQ-1:0];
                default:    ;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_trap_ctrl.sv
// Directed bench for rv32_trap_ctrl: expected values are queued when a step
// is driven and popped when the matching DUT output is sampled.
module tb_rv32_trap_ctrl;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    rv32_trap_ctrl_if #(.N_EXT_IRQ(N)) bus ();

    rv32_trap_ctrl #(
        .N_EXT_IRQ  (N),
        .RESET_MTVEC(32'h0000_1000),
        .EXT_EDGE   (8'h01)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic compare(input logic [31:0] obs);
        exp_t e;
        n_total++;
        if (sb.size() == 0) begin
            $error("FAIL sb_empty observed=%h expected=none", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.instr_commit = 1'b0;
        bus.actual_pc    = 32'd0;
        bus.exc_valid    = 1'b0;
        bus.exc_cause    = 4'd0;
        bus.exc_tval     = 32'd0;
        bus.mret_commit  = 1'b0;
        bus.csr_op       = 2'b00;
        bus.csr_addr     = 12'h000;
        bus.csr_wdata    = 32'd0;
    endtask

    task automatic csr_wr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
        bus.csr_op    = op;
        bus.csr_addr  = a;
        bus.csr_wdata = d;
        step();
        bus.csr_op    = 2'b00;
    endtask

    task automatic chk_csr(input string tag, input logic [11:0] a, input logic [31:0] v);
        expect_v(tag, v);
        bus.csr_addr = a;
        #1;
        compare(bus.csr_rdata);
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic v);
        expect_v(tag, {31'b0, v});
        compare({31'b0, obs});
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.irq_software = 1'b0;
        bus.irq_timer    = 1'b0;
        bus.irq_external = '0;
        idle();
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        chk_csr("rst_mtvec", 12'h305, 32'h0000_1000);
        chk_csr("rst_mstatus", 12'h300, 32'h0);
        chk_csr("rst_mie", 12'h304, 32'h0);
        chk_bit("rst_take_trap", bus.take_trap, 1'b0);
        rst_n = 1'b1;
        step();

        // Set/clear on mie, read-only mip, unmapped address
        csr_wr(2'b10, 12'h304, 32'h880);
        chk_csr("mie_set", 12'h304, 32'h880);
        csr_wr(2'b11, 12'h304, 32'h080);
        chk_csr("mie_clr", 12'h304, 32'h800);
        csr_wr(2'b01, 12'h344, 32'hFFFF_FFFF);
        chk_csr("mip_ro", 12'h344, 32'h0);
        chk_csr("unmapped", 12'h123, 32'h0);

        // External level interrupt on line 2
        csr_wr(2'b01, 12'hBC0, 32'h04);
        csr_wr(2'b01, 12'h300, 32'h08);
        bus.irq_external = 8'h04;
        chk_csr("mextid_pre", 12'hFC1, 32'd3);
        chk_csr("mip_ext", 12'h344, 32'h800);
        bus.instr_commit = 1'b1;
        bus.actual_pc    = 32'h200;
        #1;
        chk_bit("ext_take_trap", bus.take_trap, 1'b1);
        expect_v("ext_trap_pc", 32'h1000);
        compare(bus.trap_pc);
        chk_bit("ext_take_return", bus.take_return, 1'b0);
        step();
        idle();
        chk_csr("ext_mcause", 12'h342, 32'h8000_000B);
        chk_csr("ext_mepc", 12'h341, 32'h200);
        chk_csr("ext_mstatus", 12'h300, 32'h80);
        chk_csr("ext_mextid", 12'hFC1, 32'd3);
        bus.irq_external = '0;
        step();

        // mret with MPIE = 1
        bus.instr_commit = 1'b1;
        bus.mret_commit  = 1'b1;
        #1;
        chk_bit("mret_take_return", bus.take_return, 1'b1);
        chk_bit("mret_take_trap", bus.take_trap, 1'b0);
        expect_v("mret_return_pc", 32'h200);
        compare(bus.return_pc);
        step();
        idle();
        chk_csr("mret_mstatus", 12'h300, 32'h88);

        // Vectored timer interrupt, then direct-mode exception
        csr_wr(2'b01, 12'h305, 32'h2003);
        chk_csr("mtvec_wr", 12'h305, 32'h2001);
        csr_wr(2'b10, 12'h304, 32'h080);
        chk_csr("mie_tm", 12'h304, 32'h880);
        bus.irq_timer    = 1'b1;
        bus.instr_commit = 1'b1;
        bus.actual_pc    = 32'h300;
        #1;
        chk_bit("tm_take_trap", bus.take_trap, 1'b1);
        expect_v("tm_trap_pc", 32'h201C);
        compare(bus.trap_pc);
        step();
        idle();
        bus.irq_timer = 1'b0;
        chk_csr("tm_mcause", 12'h342, 32'h8000_0007);
        chk_csr("tm_mstatus", 12'h300, 32'h80);
        chk_csr("tm_mtval", 12'h343, 32'h0);
        step();

        bus.instr_commit = 1'b1;
        bus.exc_valid    = 1'b1;
        bus.exc_cause    = 4'd2;
        bus.exc_tval     = 32'hDEAD_BEEF;
        bus.actual_pc    = 32'h304;
        #1;
        chk_bit("exc_take_trap", bus.take_trap, 1'b1);
        expect_v("exc_trap_pc", 32'h2000);
        compare(bus.trap_pc);
        step();
        idle();
        chk_csr("exc_mcause", 12'h342, 32'h2);
        chk_csr("exc_mtval", 12'h343, 32'hDEAD_BEEF);
        chk_csr("exc_mepc", 12'h341, 32'h304);
        step();

        // Everything in one commit cycle: exception wins, CSR write dropped
        csr_wr(2'b01, 12'h340, 32'h1234);
        chk_csr("mscratch_wr", 12'h340, 32'h1234);
        csr_wr(2'b10, 12'h300, 32'h08);
        chk_csr("mstatus_set", 12'h300, 32'h08);
        csr_wr(2'b10, 12'h304, 32'h08);
        chk_csr("mie_sw", 12'h304, 32'h888);
        step();
        bus.irq_software = 1'b1;
        bus.instr_commit = 1'b1;
        bus.exc_valid    = 1'b1;
        bus.exc_cause    = 4'd4;
        bus.exc_tval     = 32'h55;
        bus.mret_commit  = 1'b1;
        bus.actual_pc    = 32'h401;
        bus.csr_op       = 2'b01;
        bus.csr_addr     = 12'h340;
        bus.csr_wdata    = 32'hAAAA;
        #1;
        chk_bit("all_take_trap", bus.take_trap, 1'b1);
        chk_bit("all_take_return", bus.take_return, 1'b0);
        expect_v("all_trap_pc", 32'h2000);
        compare(bus.trap_pc);
        step();
        idle();
        bus.irq_software = 1'b0;
        chk_csr("all_mscratch", 12'h340, 32'h1234);
        chk_csr("all_mcause", 12'h342, 32'h4);
        chk_csr("all_mepc", 12'h341, 32'h400);
        chk_csr("all_mtval", 12'h343, 32'h55);
        step();

        // Edge-latched line 0
        bus.irq_external = 8'h01;
        step();
        bus.irq_external = 8'h00;
        chk_csr("edge_latch", 12'hFC0, 32'h01);
        step();
        chk_csr("edge_hold", 12'hFC0, 32'h01);
        step();
        csr_wr(2'b01, 12'hBC1, 32'h01);
        chk_csr("edge_clr", 12'hFC0, 32'h00);
        chk_csr("mextclr_rd", 12'hBC1, 32'h00);
        step();
        bus.irq_external = 8'h01;
        csr_wr(2'b01, 12'hBC1, 32'h01);
        bus.irq_external = 8'h00;
        chk_csr("edge_clr_race", 12'hFC0, 32'h01);
        bus.irq_external = 8'h08;
        chk_csr("level_plus_edge", 12'hFC0, 32'h09);
        chk_csr("mextid_none", 12'hFC1, 32'd0);
        bus.irq_external = 8'h00;
        step();

        // Asynchronous reset mid-operation
        #2;
        rst_n = 1'b0;
        #1;
        chk_csr("arst_mextip", 12'hFC0, 32'h0);
        chk_csr("arst_mstatus", 12'h300, 32'h0);
        chk_csr("arst_mtvec", 12'h305, 32'h1000);
        chk_csr("arst_mscratch", 12'h340, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        if (sb.size() != 0) begin
            n_total++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
